// File: rtl/umi_packet_split.sv
// rtl/umi_packet_split.sv - cuts wide UMI packets into chunks of at most ODW data bits
// Optional split counter: UMI_PACKET_SPLIT_STATS_EN
module umi_packet_split #(
  parameter int CW  = 32,
  parameter int AW  = 64,
  parameter int IDW = 256,
  parameter int ODW = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           umi_in_valid,
  input  logic [CW-1:0]  umi_in_cmd,
  input  logic [AW-1:0]  umi_in_dstaddr,
  input  logic [AW-1:0]  umi_in_srcaddr,
  input  logic [IDW-1:0] umi_in_data,
  output logic           umi_in_ready,
  output logic           umi_out_valid,
  output logic [CW-1:0]  umi_out_cmd,
  output logic [AW-1:0]  umi_out_dstaddr,
  output logic [AW-1:0]  umi_out_srcaddr,
  output logic [ODW-1:0] umi_out_data,
  input  logic           umi_out_ready,
  output logic [15:0]    split_count
);

  localparam int OB     = ODW / 8;
  localparam int RW     = $clog2(IDW / 8) + 1;
  localparam int LOG_OB = $clog2(OB);

  localparam logic [4:0] OP_REQ_WRITE  = 5'h03;
  localparam logic [4:0] OP_REQ_POSTED = 5'h05;
  localparam logic [4:0] OP_RESP_READ  = 5'h02;

  typedef enum logic {IDLE, SEND} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cmd_q, cmd_d;
  logic [AW-1:0]  dst_q, dst_d;
  logic [AW-1:0]  src_q, src_d;
  logic [IDW-1:0] data_q, data_d;
  logic [RW-1:0]  rem_q, rem_d;
  logic           split_q, split_d;

  logic [4:0]     in_opcode;
  logic [2:0]     in_size;
  logic [7:0]     in_len;
  logic [RW-1:0]  in_rem;
  logic           in_split;
  logic [2:0]     size_q;
  logic [RW-1:0]  chunk_bytes;
  logic           last_chunk;
  logic           in_commit;
  logic           out_commit;

  // Command field positions: opcode[4:0], size[7:5], len[15:8], eom[22]
  assign in_opcode = umi_in_cmd[4:0];
  assign in_size   = umi_in_cmd[7:5];
  assign in_len    = umi_in_cmd[15:8];
  assign in_rem    = RW'(({8'd0, in_len} + 16'd1) << in_size);
  assign in_split  = ((in_opcode == OP_REQ_WRITE) || (in_opcode == OP_REQ_POSTED) ||
                      (in_opcode == OP_RESP_READ)) &&
                     (in_size <= 3'(LOG_OB)) && (in_rem > RW'(OB));

  assign size_q      = cmd_q[7:5];
  assign chunk_bytes = (rem_q <= RW'(OB)) ? rem_q : RW'(OB);
  assign last_chunk  = !split_q || (rem_q <= RW'(OB));

  assign umi_out_valid = (state_q == SEND);
  assign out_commit    = umi_out_valid && umi_out_ready;
  assign umi_in_ready  = (state_q == IDLE) || (out_commit && last_chunk);
  assign in_commit     = umi_in_valid && umi_in_ready;

  assign umi_out_dstaddr = dst_q;
  assign umi_out_srcaddr = src_q;

  always_comb begin
    umi_out_cmd = cmd_q;
    if (split_q) begin
      umi_out_cmd[15:8] = 8'(chunk_bytes >> size_q) - 8'd1;
      umi_out_cmd[22]   = cmd_q[22] && last_chunk;
    end
  end

  // Bytes past the end of a short final chunk are zeroed
  always_comb begin
    umi_out_data = data_q[ODW-1:0];
    if (split_q) begin
      for (int i = 0; i < OB; i++) begin
        if (RW'(i) >= chunk_bytes) umi_out_data[8*i +: 8] = 8'h00;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    dst_d   = dst_q;
    src_d   = src_q;
    data_d  = data_q;
    rem_d   = rem_q;
    split_d = split_q;
    if (in_commit) begin
      state_d = SEND;
      cmd_d   = umi_in_cmd;
      dst_d   = umi_in_dstaddr;
      src_d   = umi_in_srcaddr;
      data_d  = umi_in_data;
      rem_d   = in_rem;
      split_d = in_split;
    end else if (out_commit) begin
      if (!last_chunk) begin
        rem_d  = rem_q - RW'(OB);
        data_d = data_q >> ODW;
        dst_d  = dst_q + AW'(OB);
        src_d  = src_q + AW'(OB);
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      dst_q   <= '0;
      src_q   <= '0;
      data_q  <= '0;
      rem_q   <= '0;
      split_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      split_q <= split_d;
    end
  end

`ifdef UMI_PACKET_SPLIT_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (out_commit && last_chunk && split_q && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign split_count = cnt_q;
`else
  assign split_count = 16'h0;
`endif

endmodule

// File: tb/tb_umi_packet_split.sv
// tb/tb_umi_packet_split.sv - scoreboard bench for umi_packet_split
module tb_umi_packet_split;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [31:0]  in_cmd;
  logic [63:0]  in_dst;
  logic [63:0]  in_src;
  logic [255:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [31:0]  out_cmd;
  logic [63:0]  out_dst;
  logic [63:0]  out_src;
  logic [63:0]  out_data;
  logic         out_ready;
  logic [15:0]  split_count;

  umi_packet_split #(.CW(32), .AW(64), .IDW(256), .ODW(64)) dut (
    .clk             (clk),
    .reset           (reset),
    .umi_in_valid    (in_valid),
    .umi_in_cmd      (in_cmd),
    .umi_in_dstaddr  (in_dst),
    .umi_in_srcaddr  (in_src),
    .umi_in_data     (in_data),
    .umi_in_ready    (in_ready),
    .umi_out_valid   (out_valid),
    .umi_out_cmd     (out_cmd),
    .umi_out_dstaddr (out_dst),
    .umi_out_srcaddr (out_src),
    .umi_out_data    (out_data),
    .umi_out_ready   (out_ready),
    .split_count     (split_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cmd;
    logic [63:0] dst;
    logic [63:0] src;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] mk_cmd(input logic [4:0] op, input logic [2:0] size,
                                         input logic [7:0] len, input logic eom);
    return {5'h1A, 2'b01, 1'b1, 1'b0, eom, 2'b10, 4'h5, len, size, op};
  endfunction

  function automatic logic [15:0] exp_sc(input int n);
`ifdef UMI_PACKET_SPLIT_STATS_EN
    return 16'(n);
`else
    return 16'(n * 0);
`endif
  endfunction

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%0h/%0h expected=none", out_cmd, out_dst);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_cmd",  256'(out_cmd),  256'(mon_e.cmd));
        chk("out_dst",  256'(out_dst),  256'(mon_e.dst));
        chk("out_src",  256'(out_src),  256'(mon_e.src));
        chk("out_data", 256'(out_data), 256'(mon_e.data));
      end
    end
  end

  task automatic push(input logic [31:0] c, input logic [63:0] d, input logic [63:0] s,
                      input logic [63:0] dat);
    exp_t e;
    e.cmd = c; e.dst = d; e.src = s; e.data = dat;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic send(input logic [31:0] c, input logic [63:0] d, input logic [63:0] s,
                      input logic [255:0] dat);
    int n = 0;
    in_valid = 1'b1; in_cmd = c; in_dst = d; in_src = s; in_data = dat;
    #1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=not_ready expected=ready");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || out_valid) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d pending expected=0", exp_q.size());
    end
  endtask

  logic [255:0] seq_data;

  // 32-byte write, size 0, bytes 0x00..0x1F -> four 8-byte chunks
  task automatic push_case1(input logic [63:0] d, input logic [63:0] s);
    push(mk_cmd(5'h03, 3'd0, 8'd7, 1'b0), d,          s,          64'h0706050403020100);
    push(mk_cmd(5'h03, 3'd0, 8'd7, 1'b0), d + 64'h08, s + 64'h08, 64'h0F0E0D0C0B0A0908);
    push(mk_cmd(5'h03, 3'd0, 8'd7, 1'b0), d + 64'h10, s + 64'h10, 64'h1716151413121110);
    push(mk_cmd(5'h03, 3'd0, 8'd7, 1'b1), d + 64'h18, s + 64'h18, 64'h1F1E1D1C1B1A1918);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) seq_data[8*i +: 8] = 8'(i);
    reset = 1'b1; in_valid = 1'b0; in_cmd = '0; in_dst = '0; in_src = '0; in_data = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_in_ready",  256'(in_ready),  256'(1));
    chk("rst_out_cmd",   256'(out_cmd),   256'(0));
    chk("rst_out_dst",   256'(out_dst),   256'(0));
    chk("rst_out_src",   256'(out_src),   256'(0));
    chk("rst_out_data",  256'(out_data),  256'(0));
    chk("rst_split_cnt", 256'(split_count), 256'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    push_case1(64'h1000, 64'h8000);
    send(mk_cmd(5'h03, 3'd0, 8'd31, 1'b1), 64'h1000, 64'h8000, seq_data);
    chk("case1_latency", 256'(out_valid), 256'(1));
    wait_drain();
    chk("case1_split_cnt", 256'(split_count), 256'(exp_sc(1)));

    push(mk_cmd(5'h05, 3'd3, 8'd0, 1'b1), 64'h2000, 64'h2100, 64'h1122334455667788);
    send(mk_cmd(5'h05, 3'd3, 8'd0, 1'b1), 64'h2000, 64'h2100,
         256'h1122334455667788);
    chk("posted_latency",  256'(out_valid), 256'(1));
    chk("posted_in_ready", 256'(in_ready),  256'(1));
    wait_drain();

    push(mk_cmd(5'h01, 3'd2, 8'd63, 1'b1), 64'h3000, 64'h3100, 64'h0123456789ABCDEF);
    send(mk_cmd(5'h01, 3'd2, 8'd63, 1'b1), 64'h3000, 64'h3100,
         {192'hABABABABABABABABABABABABABABABABABABABABABABABAB, 64'h0123456789ABCDEF});
    wait_drain();
    chk("read_split_cnt", 256'(split_count), 256'(exp_sc(1)));

    push(mk_cmd(5'h02, 3'd1, 8'd3, 1'b0), 64'hFFFF_FFFF_FFFF_FFF8, 64'h2000, 64'h8877665544332211);
    push(mk_cmd(5'h02, 3'd1, 8'd1, 1'b1), 64'h0,                  64'h2008, 64'h00000000CCBBAA99);
    send(mk_cmd(5'h02, 3'd1, 8'd5, 1'b1), 64'hFFFF_FFFF_FFFF_FFF8, 64'h2000,
         256'hDEADBEEF_CCBBAA99_8877665544332211);
    wait_drain();
    chk("rresp_split_cnt", 256'(split_count), 256'(exp_sc(2)));

    push_case1(64'h1000, 64'h8000);
    send(mk_cmd(5'h03, 3'd0, 8'd31, 1'b1), 64'h1000, 64'h8000, seq_data);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stall_valid", 256'(out_valid), 256'(1));
      chk("stall_dst",   256'(out_dst),   256'(64'h1008));
      chk("stall_data",  256'(out_data),  256'(64'h0F0E0D0C0B0A0908));
      chk("stall_cmd",   256'(out_cmd),   256'(mk_cmd(5'h03, 3'd0, 8'd7, 1'b0)));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    push_case1(64'h4000, 64'h9000);
    send(mk_cmd(5'h03, 3'd0, 8'd31, 1'b1), 64'h4000, 64'h9000, seq_data);
    chk("b2b_no_bubble", 256'(out_valid), 256'(1));
    chk("b2b_first_dst", 256'(out_dst),   256'(64'h4000));
    wait_drain();
    chk("b2b_split_cnt", 256'(split_count), 256'(exp_sc(4)));

    push_case1(64'h1000, 64'h8000);
    send(mk_cmd(5'h03, 3'd0, 8'd31, 1'b1), 64'h1000, 64'h8000, seq_data);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", 256'(out_valid),   256'(0));
    chk("midrst_in_ready",  256'(in_ready),    256'(1));
    chk("midrst_split_cnt", 256'(split_count), 256'(0));
    reset = 1'b0;
    exp_q.delete();
    repeat (3) begin
      @(posedge clk); #1;
      chk("midrst_quiet", 256'(out_valid), 256'(0));
    end

    for (int p = 0; p < 2; p++) begin
      push_case1(64'h5000, 64'hA000);
      send(mk_cmd(5'h03, 3'd0, 8'd31, 1'b1), 64'h5000, 64'hA000, seq_data);
      wait_drain();
    end
    chk("final_split_cnt", 256'(split_count), 256'(exp_sc(2)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
